if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register, IF/ID register and a BOOT/RUN/HOLD fetch FSM.
// Define FETCH_JAL_PREDECODE_EN to steer fetch to JAL targets early.
module if_fetch_unit #(
    parameter int            AW       = 10,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          CLK,
    input  logic          RST,
    output logic [AW-1:0] iaddr,
    input  logic [31:0]   idata,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          if_valid,
    output logic [31:0]   if_instr,
    output logic [AW-1:0] if_pc,
    output logic          if_pred_taken,
    output logic [31:0]   fetch_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } state_t;

    typedef struct packed {
        logic          valid;
        logic [31:0]   instr;
        logic [AW-1:0] pc;
        logic          pred_taken;
    } if_id_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;
    if_id_t        ifid_q;
    if_id_t        ifid_d;
    if_id_t        bubble;
    logic [31:0]   cnt_q;
    logic [31:0]   cnt_d;
    logic [31:0]   cnt_inc;

    logic          do_redirect;
    logic          do_boot;
    logic          do_hold;
    logic          do_fetch;

    logic [AW-1:0] seq_pc;
    logic [AW-1:0] jal_pc;
    logic          jal_hit;

    // Exactly one action per cycle; redirect outranks boot, stall and fetch.
    assign do_redirect = redirect;
    assign do_boot     = !redirect && (state_q == BOOT);
    assign do_hold     = !redirect && (state_q != BOOT) && stall;
    assign do_fetch    = !redirect && (state_q != BOOT) && !stall;

    assign seq_pc  = pc_q + AW'(1);
    assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

`ifdef FETCH_JAL_PREDECODE_EN
    localparam logic [6:0] OP_JAL = 7'b110_1111;

    // Word offset is imm[20:2]; imm[1] set means a half-word target.
    logic [18:0] jal_woff;

    assign jal_woff = {idata[31], idata[19:12], idata[20], idata[30:22]};
    assign jal_hit  = (idata[6:0] == OP_JAL) && !idata[21];
    assign jal_pc   = pc_q + AW'($signed(jal_woff));
`else
    assign jal_hit = 1'b0;
    assign jal_pc  = seq_pc;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:      state_d = RUN;
            RUN, HOLD: state_d = do_hold ? HOLD : RUN;
            default:   state_d = BOOT;
        endcase
    end

    always_comb begin
        bubble = '{
            valid:      1'b0,
            instr:      NOP,
            pc:         pc_q,
            pred_taken: 1'b0
        };
        pc_d   = pc_q;
        ifid_d = ifid_q;
        cnt_d  = cnt_q;
        unique case (1'b1)
            do_redirect: begin
                pc_d   = redirect_pc;
                ifid_d = bubble;
            end
            do_boot: begin
                ifid_d = bubble;
            end
            do_hold: begin
                pc_d = pc_q;
            end
            do_fetch: begin
                pc_d   = jal_hit ? jal_pc : seq_pc;
                ifid_d = '{
                    valid:      1'b1,
                    instr:      idata,
                    pc:         pc_q,
                    pred_taken: jal_hit
                };
                cnt_d  = cnt_inc;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q   <= RESET_PC;
            ifid_q <= '{
                valid:      1'b0,
                instr:      NOP,
                pc:         RESET_PC,
                pred_taken: 1'b0
            };
            cnt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
            cnt_q  <= cnt_d;
        end
    end

    assign iaddr         = pc_q;
    assign if_valid      = ifid_q.valid;
    assign if_instr      = ifid_q.instr;
    assign if_pc         = ifid_q.pc;
    assign if_pred_taken = ifid_q.pred_taken;
    assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and random fetch traffic against a
// cycle-level reference model of the fetch rules.
module tb_if_fetch_unit;

    localparam int          AW  = 10;
    localparam int          DEP = 1 << AW;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          CLK;
    logic          RST;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] iaddr;
    logic [31:0]   idata;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic [AW-1:0] if_pc;
    logic          if_pred_taken;
    logic [31:0]   fetch_cnt;

    logic          rst_s;
    logic [3:0]    iaddr_s;
    logic [31:0]   idata_s;
    logic          if_valid_s;
    logic [31:0]   if_instr_s;
    logic [3:0]    if_pc_s;
    logic          if_pred_taken_s;
    logic [31:0]   fetch_cnt_s;

    logic [31:0] rom   [DEP];
    logic [31:0] rom_s [16];

    assign idata   = rom[iaddr];
    assign idata_s = rom_s[iaddr_s];

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_known = 0;
    bit          m_boot  = 0;
    int          m_pc    = 0;
    bit          m_valid = 0;
    logic [31:0] m_instr = NOP;
    int          m_ifpc  = 0;
    bit          m_pt    = 0;
    logic [31:0] m_cnt   = 0;

    if_fetch_unit u_dut (
        .CLK           (CLK),
        .RST           (RST),
        .iaddr         (iaddr),
        .idata         (idata),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .fetch_cnt     (fetch_cnt)
    );

    if_fetch_unit #(
        .AW       (4),
        .RESET_PC (4'd0)
    ) u_small (
        .CLK           (CLK),
        .RST           (rst_s),
        .iaddr         (iaddr_s),
        .idata         (idata_s),
        .stall         (1'b0),
        .redirect      (1'b0),
        .redirect_pc   (4'd0),
        .if_valid      (if_valid_s),
        .if_instr      (if_instr_s),
        .if_pc         (if_pc_s),
        .if_pred_taken (if_pred_taken_s),
        .fetch_cnt     (fetch_cnt_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    // One clock of the fetch rules, from the inputs seen at the edge.
    task automatic model_step();
        logic [31:0] ins;
        if (RST) begin
            m_known = 1;
            m_boot  = 1;
            m_pc    = 0;
            m_valid = 0;
            m_instr = NOP;
            m_ifpc  = 0;
            m_pt    = 0;
            m_cnt   = 0;
        end else if (!m_known) begin
            m_known = 0;
        end else if (m_boot || redirect) begin
            m_valid = 0;
            m_instr = NOP;
            m_ifpc  = m_pc;
            m_pt    = 0;
            if (redirect) m_pc = int'(redirect_pc);
            m_boot  = 0;
        end else if (!stall) begin
            ins     = rom[m_pc];
            m_valid = 1;
            m_instr = ins;
            m_ifpc  = m_pc;
            m_pt    = 0;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            m_pc    = (m_pc + 1) % DEP;
`ifdef FETCH_JAL_PREDECODE_EN
            begin
                logic [20:0] imm;
                int          simm;
                imm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                if (ins[6:0] == 7'b110_1111 && !imm[1]) begin
                    simm = imm[20] ? int'(imm) - (1 << 21) : int'(imm);
                    m_pc = (((m_ifpc + simm / 4) % DEP) + DEP) % DEP;
                    m_pt = 1;
                end
            end
`endif
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        if (m_known) begin
            chk("iaddr", 32'(iaddr), 32'(m_pc));
            chk("if_valid", 32'(if_valid), 32'(m_valid));
            chk("if_instr", if_instr, m_instr);
            chk("if_pc", 32'(if_pc), 32'(m_ifpc));
            chk("if_pred_taken", 32'(if_pred_taken), 32'(m_pt));
            chk("fetch_cnt", fetch_cnt, m_cnt);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_iaddr"}, 32'(iaddr), 32'd0);
        chk({tag, "_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_instr"}, if_instr, NOP);
        chk({tag, "_pc"}, 32'(if_pc), 32'd0);
        chk({tag, "_pt"}, 32'(if_pred_taken), 32'd0);
        chk({tag, "_cnt"}, fetch_cnt, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        RST         = 1;
        rst_s       = 1;
        stall       = 0;
        redirect    = 0;
        redirect_pc = '0;
        for (int i = 0; i < DEP; i++) begin
            r      = $urandom();
            rom[i] = {r[31:7], 7'b001_0011};
        end
        rom[0] = 32'h0000_0037;
        rom[1] = NOP;
        rom[2] = 32'h0000_0023;
        for (int i = 0; i < 16; i++) rom_s[i] = NOP;

        // Reset, boot bubble, then free-running fetch
        tick();
        chk_reset_state("rst");
        RST = 0;
        tick();
        chk("boot_iaddr", 32'(iaddr), 32'd0);
        chk("boot_valid", 32'(if_valid), 32'd0);
        tick();
        chk("run1_iaddr", 32'(iaddr), 32'd1);
        chk("run1_valid", 32'(if_valid), 32'd1);
        chk("run1_instr", if_instr, 32'h0000_0037);
        tick();
        chk("run2_iaddr", 32'(iaddr), 32'd2);
        tick();
        chk("run3_iaddr", 32'(iaddr), 32'd3);
        chk("run3_cnt", fetch_cnt, 32'd3);

        // Stall at iaddr 5
        tick();
        tick();
        chk("pre_stall_iaddr", 32'(iaddr), 32'd5);
        stall = 1;
        repeat (3) begin
            tick();
            chk("stall_iaddr", 32'(iaddr), 32'd5);
            chk("stall_if_pc", 32'(if_pc), 32'd4);
            chk("stall_cnt", fetch_cnt, 32'd5);
        end
        stall = 0;
        tick();
        chk("release_if_pc", 32'(if_pc), 32'd5);
        chk("release_valid", 32'(if_valid), 32'd1);

        // Redirect beats stall at iaddr 12
        repeat (6) tick();
        chk("at12", 32'(iaddr), 32'd12);
        redirect    = 1;
        redirect_pc = 10'd2;
        stall       = 1;
        tick();
        chk("redir_iaddr", 32'(iaddr), 32'd2);
        chk("redir_valid", 32'(if_valid), 32'd0);
        redirect = 0;
        stall    = 0;
        tick();
        chk("redir_if_pc", 32'(if_pc), 32'd2);
        chk("redir_valid2", 32'(if_valid), 32'd1);

        // JAL imm=-8 at address 18
        rom[18]     = 32'hFF9F_F06F;
        redirect    = 1;
        redirect_pc = 10'd18;
        tick();
        redirect = 0;
        tick();
        chk("jal_if_pc", 32'(if_pc), 32'd18);
        chk("jal_valid", 32'(if_valid), 32'd1);
`ifdef FETCH_JAL_PREDECODE_EN
        chk("jal_iaddr", 32'(iaddr), 32'd16);
        chk("jal_pt", 32'(if_pred_taken), 32'd1);
`else
        chk("jal_iaddr", 32'(iaddr), 32'd19);
        chk("jal_pt", 32'(if_pred_taken), 32'd0);
`endif

        // Reset overrides redirect mid-run
        redirect    = 1;
        redirect_pc = 10'd9;
        tick();
        chk("at9", 32'(iaddr), 32'd9);
        redirect_pc = 10'd7;
        RST         = 1;
        tick();
        chk_reset_state("mid_rst");
        RST      = 0;
        redirect = 0;

        // Random traffic with JALs of every shape
        for (int i = 0; i < DEP; i++) begin
            r = $urandom();
            if (r[3:0] < 4) rom[i] = {r[31:7], 7'b110_1111};
            else            rom[i] = {r[31:7], 7'b001_0011};
        end
        for (int n = 0; n < 3000; n++) begin
            r           = $urandom();
            stall       = (r[2:0] < 3'd2);
            redirect    = (r[6:3] == 4'd0);
            redirect_pc = r[31:22];
            RST         = (r[15:8] == 8'd0);
            tick();
        end
        RST      = 0;
        stall    = 0;
        redirect = 0;

        // AW=4 instance: wrap 15 -> 0 without a bubble
        tick();
        rst_s = 0;
        tick();
        chk("s_boot_iaddr", 32'(iaddr_s), 32'd0);
        chk("s_boot_valid", 32'(if_valid_s), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("s_iaddr", 32'(iaddr_s), 32'(k % 16));
            chk("s_valid", 32'(if_valid_s), 32'd1);
            chk("s_if_pc", 32'(if_pc_s), 32'((k - 1) % 16));
            chk("s_instr", if_instr_s, NOP);
            chk("s_pt", 32'(if_pred_taken_s), 32'd0);
        end
        chk("s_cnt", fetch_cnt_s, 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
